// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: opcodes, FSM encoding and decoder result type shared by the
// pipeline controller and the decode-side blocks.
package hazard_ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
    typedef struct packed {
        logic       use1;
        logic       use2;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } src_use_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-controller signal bundle; master is the datapath,
// slave is the sequencing controller.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [31:0]      id_instr;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_sel;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output id_instr, ex_rd, ex_mem_read, ex_redirect, mem_req, mem_ready,
        input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_bubble, halted, mem_err, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_instr, ex_rd, ex_mem_read, ex_redirect, mem_req, mem_ready,
        output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_bubble, halted, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_src_use_dec.sv
// hazard_ctrl_src_use_dec: which register sources the ID-stage instruction reads.
module hazard_ctrl_src_use_dec
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output src_use_t    su
);
    logic [6:0] op;
    logic       unused_bits;
    assign op          = instr[6:0];
    assign unused_bits = ^{instr[31:25], instr[14:7]};
    always_comb begin
        su.rs1  = instr[19:15];
        su.rs2  = instr[24:20];
        su.use1 = op inside {OP_R, OP_STORE, OP_BRANCH, OP_IMM, OP_LOAD, OP_JALR};
        su.use2 = op inside {OP_R, OP_STORE, OP_BRANCH};
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencing (load-use bubbles, redirect flushes,
// dmem-wait freeze) with a memory-timeout halt FSM and saturating perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int WW = $clog2(MEM_TIMEOUT);
    state_t           state, nxt;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             halted, mem_err;
    logic             mem_busy, load_use, frz, redir, lu;
    src_use_t         su;
    hazard_ctrl_src_use_dec u_dec (.instr(bus.id_instr), .su(su));
    assign mem_busy = bus.mem_req & ~bus.mem_ready;
    assign load_use = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                      ((su.use1 & (su.rs1 == bus.ex_rd)) | (su.use2 & (su.rs2 == bus.ex_rd)));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            halted   <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state    <= nxt;
            wait_cnt <= (state == MEM_WAIT && nxt == MEM_WAIT) ? wait_cnt + 1'b1 : '0;
            halted   <= nxt == HALT;
            mem_err  <= nxt == HALT;
        end
    end
    // the busy cycle seen in RUN is wait 0, so the halt needs MEM_TIMEOUT+1 busy cycles
    always_comb begin
        nxt = state == HALT ? HALT :
              !mem_busy     ? RUN  :
              (state == MEM_WAIT && wait_cnt == WW'(MEM_TIMEOUT - 1)) ? HALT : MEM_WAIT;
    end
    always_comb begin
        frz               = ~rst_n | (state == HALT) | mem_busy;
        redir             = ~frz & bus.ex_redirect;
        lu                = ~frz & ~bus.ex_redirect & load_use;
        bus.pc_write      = ~frz & ~lu;
        bus.pc_sel        = redir;
        bus.if_id_write   = ~frz & ~lu;
        bus.if_id_flush   = redir;
        bus.id_ex_write   = ~frz;
        bus.id_ex_flush   = redir | lu;
        bus.ex_mem_write  = ~frz;
        bus.mem_wb_bubble = frz;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!bus.pc_write && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (redir && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
    assign bus.halted    = halted;
    assign bus.mem_err   = mem_err;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
endmodule
